data_mem_arbiter: RTL and testbench

- Shares the single data_memory port between two requesters: the cpu data port (port C) and the UART debug/loader engine (port D).
- Sits between cpu/debug and data_memory in the top level, on the same divided clk.
- CPU has default priority; a streak limit guarantees debug progress.
- Debug can lock the memory, blocking the CPU for multi-word loads and inspection.

---
 rtl/data_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_data_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the single data_memory port.
// Port C (cpu) has default priority. A streak counter lets the debug port (D)
// win once after MAX_CPU_STREAK consecutive contested cpu grants, so D always
// makes progress. Debug can lock the memory, which blocks the cpu until
// dbg_lock is released. Read data comes back one cycle after the grant, and a
// read tag steers the rvalid strobe to whichever port issued the read.
module data_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_CPU_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  // cpu data port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  // debug / loader port
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              lock_active,
  // data_memory side
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_memwrite,
  output logic              mem_memread,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    NORMAL = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CPU  = 2'd1,
    TAG_DBG  = 2'd2
  } rtag_t;

  // The streak counter is 4 bits wide, enough for the full legal range 1..15.
  localparam logic [3:0] STREAK_MAX = 4'(MAX_CPU_STREAK);

  state_t      state;
  logic [3:0]  streak;
  rtag_t       rtag;

  logic        cpu_win;
  logic        dbg_win;

  // Grant decision from the live request lines and the registered state.
  // Reset forces both grants low so nothing reaches memory while rst is high.
  always_comb begin
    cpu_win = 1'b0;
    dbg_win = 1'b0;
    if (!rst) begin
      if (state == LOCKED) begin
        dbg_win = dbg_req;
      end else if (cpu_req && dbg_req) begin
        if (streak < STREAK_MAX) begin
          cpu_win = 1'b1;
        end else begin
          dbg_win = 1'b1;
        end
      end else begin
        cpu_win = cpu_req;
        dbg_win = dbg_req;
      end
    end
  end

  assign cpu_gnt = cpu_win;
  assign dbg_gnt = dbg_win;

  // Steer the winner onto the memory port; with no winner the cpu bus is
  // passed through with both strobes low.
  always_comb begin
    mem_addr     = cpu_addr;
    mem_wdata    = cpu_wdata;
    mem_memwrite = 1'b0;
    mem_memread  = 1'b0;
    if (dbg_win) begin
      mem_addr     = dbg_addr;
      mem_wdata    = dbg_wdata;
      mem_memwrite = dbg_we;
      mem_memread  = ~dbg_we;
    end else if (cpu_win) begin
      mem_memwrite = cpu_we;
      mem_memread  = ~cpu_we;
    end
  end

  // Lock state machine, fairness streak and read-return tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= NORMAL;
      streak <= 4'd0;
      rtag   <= TAG_NONE;
    end else begin
      if (cpu_win && !cpu_we) begin
        rtag <= TAG_CPU;
      end else if (dbg_win && !dbg_we) begin
        rtag <= TAG_DBG;
      end else begin
        rtag <= TAG_NONE;
      end

      case (state)
        NORMAL: begin
          if (dbg_lock) begin
            state  <= LOCKED;
            streak <= 4'd0;
          end else if (cpu_win && dbg_req) begin
            streak <= streak + 4'd1;
          end else begin
            streak <= 4'd0;
          end
        end
        LOCKED: begin
          streak <= 4'd0;
          if (!dbg_lock) begin
            state <= NORMAL;
          end
        end
        default: begin
          state  <= NORMAL;
          streak <= 4'd0;
        end
      endcase
    end
  end

  // Status and read-return outputs. A read tag left over from before reset
  // is masked so an in-flight read is dropped.
  assign lock_active = (state == LOCKED) && !rst;
  assign cpu_rvalid  = (rtag == TAG_CPU) && !rst;
  assign dbg_rvalid  = (rtag == TAG_DBG) && !rst;
  assign cpu_rdata   = mem_rdata;
  assign dbg_rdata   = mem_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a vector table of per-cycle inputs and expected
// grants, a small behavioural data memory, and a scoreboard queue holding the
// read result expected one cycle after each granted read.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid, lock_active;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_memwrite, mem_memread;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic        c_req;
    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_lock;
    logic        e_cgnt;
    logic        e_dgnt;
    logic        e_lock;
  } vec_t;

  typedef struct packed {
    logic        c_v;
    logic        d_v;
    logic [31:0] data;
  } rexp_t;

  vec_t  vecs[$];
  rexp_t sb[$];

  logic        init_mem;
  logic [31:0] mem_model [0:255];
  logic [31:0] ref_mem   [0:255];

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_CPU_STREAK(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req),
    .dbg_we(dbg_we),
    .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock),
    .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata),
    .lock_active(lock_active),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_memwrite(mem_memwrite),
    .mem_memread(mem_memread),
    .mem_rdata(mem_rdata)
  );

  // Behavioural data_memory: write commits at the edge, read data one cycle later.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem_model[i] <= 32'h5A00_0000 | 32'(i);
      mem_model[8'h10] <= 32'hDEAD_BEEF;
    end else begin
      if (mem_memwrite) mem_model[mem_addr[7:0]] <= mem_wdata;
      if (mem_memread)  mem_rdata <= mem_model[mem_addr[7:0]];
    end
  end

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  task automatic addVec(input logic r, input logic cr, input logic cw,
                        input logic [31:0] ca, input logic [31:0] cd,
                        input logic dr, input logic dw,
                        input logic [31:0] da, input logic [31:0] dd,
                        input logic dl, input logic ecg, input logic edg,
                        input logic el);
    vec_t v;
    v.rst = r;  v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd;
    v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dd; v.d_lock = dl;
    v.e_cgnt = ecg; v.e_dgnt = edg; v.e_lock = el;
    vecs.push_back(v);
  endtask

  // Drive one cycle just after the edge, check at the falling edge, then
  // queue the read result this cycle should produce on the next one.
  task automatic applyStimulus(input vec_t v, input int idx);
    rexp_t       e;
    rexp_t       n;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic        exp_rd;
    logic        exp_wr;
    rst = v.rst;
    cpu_req = v.c_req; cpu_we = v.c_we; cpu_addr = v.c_addr; cpu_wdata = v.c_wdata;
    dbg_req = v.d_req; dbg_we = v.d_we; dbg_addr = v.d_addr; dbg_wdata = v.d_wdata;
    dbg_lock = v.d_lock;
    @(negedge clk);
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    if (v.rst) e = '0;
    checkOutput("cpu_rvalid", idx, 32'(cpu_rvalid), 32'(e.c_v));
    checkOutput("dbg_rvalid", idx, 32'(dbg_rvalid), 32'(e.d_v));
    if (e.c_v) checkOutput("cpu_rdata", idx, cpu_rdata, e.data);
    if (e.d_v) checkOutput("dbg_rdata", idx, dbg_rdata, e.data);

    exp_addr  = v.e_dgnt ? v.d_addr  : v.c_addr;
    exp_wdata = v.e_dgnt ? v.d_wdata : v.c_wdata;
    exp_rd    = (v.e_cgnt && !v.c_we) || (v.e_dgnt && !v.d_we);
    exp_wr    = (v.e_cgnt && v.c_we)  || (v.e_dgnt && v.d_we);
    checkOutput("cpu_gnt",      idx, 32'(cpu_gnt),      32'(v.e_cgnt));
    checkOutput("dbg_gnt",      idx, 32'(dbg_gnt),      32'(v.e_dgnt));
    checkOutput("lock_active",  idx, 32'(lock_active),  32'(v.e_lock));
    checkOutput("mem_memread",  idx, 32'(mem_memread),  32'(exp_rd));
    checkOutput("mem_memwrite", idx, 32'(mem_memwrite), 32'(exp_wr));
    checkOutput("mem_addr",     idx, mem_addr,  exp_addr);
    checkOutput("mem_wdata",    idx, mem_wdata, exp_wdata);

    n = '0;
    if (!v.rst) begin
      if (v.e_cgnt && !v.c_we) begin
        n.c_v = 1'b1; n.data = ref_mem[v.c_addr[7:0]];
      end else if (v.e_dgnt && !v.d_we) begin
        n.d_v = 1'b1; n.data = ref_mem[v.d_addr[7:0]];
      end
      if (v.e_cgnt && v.c_we) ref_mem[v.c_addr[7:0]] = v.c_wdata;
      if (v.e_dgnt && v.d_we) ref_mem[v.d_addr[7:0]] = v.d_wdata;
    end
    sb.push_back(n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    int   s;
    rst = 1'b1; init_mem = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_lock = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h5A00_0000 | 32'(i);
    ref_mem[8'h10] = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    init_mem = 1'b0;

    //     rst cr cw addr      wdata          dr dw addr      wdata          lk cg dg lk
    // reset held with both requesting
    addVec(1, 1, 0, 32'h10, 32'h0,          1, 0, 32'h40, 32'h0,          0, 0, 0, 0);
    addVec(1, 1, 0, 32'h10, 32'h0,          1, 0, 32'h40, 32'h0,          0, 0, 0, 0);
    // contested: C,C,C,C,D twice
    addVec(0, 1, 0, 32'h10, 32'h0,          1, 0, 32'h40, 32'h0,          0, 1, 0, 0);
    addVec(0, 1, 0, 32'h14, 32'h0,          1, 0, 32'h40, 32'h0,          0, 1, 0, 0);
    addVec(0, 1, 0, 32'h18, 32'h0,          1, 0, 32'h40, 32'h0,          0, 1, 0, 0);
    addVec(0, 1, 0, 32'h1C, 32'h0,          1, 0, 32'h40, 32'h0,          0, 1, 0, 0);
    addVec(0, 1, 0, 32'h1C, 32'h0,          1, 0, 32'h40, 32'h0,          0, 0, 1, 0);
    addVec(0, 1, 0, 32'h1C, 32'h0,          1, 0, 32'h44, 32'h0,          0, 1, 0, 0);
    addVec(0, 1, 0, 32'h18, 32'h0,          1, 0, 32'h44, 32'h0,          0, 1, 0, 0);
    addVec(0, 1, 0, 32'h14, 32'h0,          1, 0, 32'h44, 32'h0,          0, 1, 0, 0);
    addVec(0, 1, 0, 32'h10, 32'h0,          1, 0, 32'h44, 32'h0,          0, 1, 0, 0);
    addVec(0, 1, 0, 32'h10, 32'h0,          1, 0, 32'h44, 32'h0,          0, 0, 1, 0);
    // C alone is granted every cycle
    addVec(0, 1, 0, 32'h10, 32'h0,          0, 0, 32'h48, 32'h0,          0, 1, 0, 0);
    addVec(0, 1, 0, 32'h14, 32'h0,          0, 0, 32'h48, 32'h0,          0, 1, 0, 0);
    addVec(0, 1, 0, 32'h18, 32'h0,          0, 0, 32'h48, 32'h0,          0, 1, 0, 0);
    addVec(0, 1, 0, 32'h1C, 32'h0,          0, 0, 32'h48, 32'h0,          0, 1, 0, 0);
    addVec(0, 1, 0, 32'h20, 32'h0,          0, 0, 32'h48, 32'h0,          0, 1, 0, 0);
    // streak restarts after dbg_req low and after a D grant
    addVec(0, 1, 0, 32'h24, 32'h0,          1, 0, 32'h48, 32'h0,          0, 1, 0, 0);
    addVec(0, 0, 0, 32'h24, 32'h0,          1, 0, 32'h48, 32'h0,          0, 0, 1, 0);
    addVec(0, 1, 0, 32'h28, 32'h0,          1, 0, 32'h4C, 32'h0,          0, 1, 0, 0);
    // C write then C read of the same address
    addVec(0, 1, 1, 32'h30, 32'hCAFE_F00D,  0, 0, 32'h4C, 32'h0,          0, 1, 0, 0);
    addVec(0, 1, 0, 32'h30, 32'h0,          0, 0, 32'h4C, 32'h0,          0, 1, 0, 0);
    addVec(0, 0, 0, 32'h34, 32'h0,          0, 0, 32'h4C, 32'h0,          0, 0, 0, 0);
    // lock: last C grant, then D-only write/read, release
    addVec(0, 1, 0, 32'h10, 32'h0,          0, 0, 32'h20, 32'h0,          1, 1, 0, 0);
    addVec(0, 1, 0, 32'h10, 32'h0,          1, 1, 32'h20, 32'h1234_5678,  1, 0, 1, 1);
    addVec(0, 1, 0, 32'h10, 32'h0,          1, 0, 32'h20, 32'h0,          1, 0, 1, 1);
    addVec(0, 1, 0, 32'h10, 32'h0,          0, 0, 32'h20, 32'h0,          1, 0, 0, 1);
    addVec(0, 1, 0, 32'h10, 32'h0,          0, 0, 32'h20, 32'h0,          0, 0, 0, 1);
    addVec(0, 1, 0, 32'h20, 32'h0,          0, 0, 32'h20, 32'h0,          0, 1, 0, 0);
    addVec(0, 0, 0, 32'h20, 32'h0,          0, 0, 32'h20, 32'h0,          0, 0, 0, 0);
    // reset drops an in-flight D read and releases a lock
    addVec(0, 0, 0, 32'h20, 32'h0,          1, 0, 32'h20, 32'h0,          0, 0, 1, 0);
    addVec(1, 1, 0, 32'h10, 32'h0,          1, 0, 32'h40, 32'h0,          0, 0, 0, 0);
    addVec(0, 1, 0, 32'h10, 32'h0,          1, 0, 32'h40, 32'h0,          1, 1, 0, 0);
    addVec(1, 1, 0, 32'h10, 32'h0,          1, 0, 32'h40, 32'h0,          1, 0, 0, 0);
    addVec(0, 1, 0, 32'h14, 32'h0,          1, 0, 32'h40, 32'h0,          0, 1, 0, 0);
    // idle cycle clears the streak before the modelled run
    addVec(0, 0, 0, 32'h0,  32'h0,          0, 0, 32'h0,  32'h0,          0, 0, 0, 0);

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Long contested run: expected winner from a streak model of the spec.
    s = 0;
    for (int k = 0; k < 20; k++) begin
      v.rst = 0; v.d_lock = 0;
      v.c_req = 1; v.c_we = 0; v.c_addr = 32'h80 + 32'(4 * k); v.c_wdata = 32'h0;
      v.d_req = 1; v.d_we = 0; v.d_addr = 32'hC0 + 32'(4 * k); v.d_wdata = 32'h0;
      v.e_lock = 0;
      if (s < 4) begin
        v.e_cgnt = 1; v.e_dgnt = 0; s = s + 1;
      end else begin
        v.e_cgnt = 0; v.e_dgnt = 1; s = 0;
      end
      applyStimulus(v, 100 + k);
    end

    // Final idle cycle collects the last read result.
    v.rst = 0; v.c_req = 0; v.c_we = 0; v.c_addr = 0; v.c_wdata = 0;
    v.d_req = 0; v.d_we = 0; v.d_addr = 0; v.d_wdata = 0; v.d_lock = 0;
    v.e_cgnt = 0; v.e_dgnt = 0; v.e_lock = 0;
    applyStimulus(v, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
